// File: rtl/i_cache_control.sv
// ---------------------------------------------------------------------------
// i_cache_control
//   Control FSM for a two-way instruction cache. Answers fetch requests in the
//   same cycle on a hit. On a miss it reads the line from L2, fills the
//   LRU-selected way, and then replays the lookup as a hit. It also keeps
//   saturating hit/miss performance counters.
//
// Ports
//   i_clk          system clock; all state changes on the rising edge
//   i_reset        synchronous, active-high reset
//   i_mem_read     fetch request (address held stable until o_mem_resp)
//   o_mem_resp     request complete; datapath read data valid this cycle
//   i_hit          datapath hit for the current address (combinational)
//   o_set_vals     fill strobe: write L2 line/tag/valid into the LRU way
//   o_lru_write    LRU update strobe for the current set
//   o_l2_read      L2 line read request
//   i_l2_resp      L2 line valid this cycle (one-cycle pulse)
//   i_perf_clr     synchronous clear of both counters
//   o_hit_count    saturating count of first-try hits
//   o_miss_count   saturating count of misses
//   o_busy         high while a refill is outstanding (ALLOCATE)
//   o_dbg_state    current FSM state (0 = IDLE, 1 = ALLOCATE)
//
// Handshake: a request is presented by holding i_mem_read high; it completes
// in the cycle where o_mem_resp is high. o_l2_read is held high until the
// single-cycle i_l2_resp pulse, which is only accepted in ALLOCATE.
// ---------------------------------------------------------------------------
module i_cache_control #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_mem_read,
  output logic                   o_mem_resp,
  input  logic                   i_hit,
  output logic                   o_set_vals,
  output logic                   o_lru_write,
  output logic                   o_l2_read,
  input  logic                   i_l2_resp,
  input  logic                   i_perf_clr,
  output logic [COUNT_WIDTH-1:0] o_hit_count,
  output logic [COUNT_WIDTH-1:0] o_miss_count,
  output logic                   o_busy,
  output logic [0:0]             o_dbg_state
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    ALLOCATE = 1'b1
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   r_replay;
  logic                   w_next_replay;
  logic [COUNT_WIDTH-1:0] r_hit_count;
  logic [COUNT_WIDTH-1:0] r_miss_count;
  logic                   w_hit_inc;
  logic                   w_miss_inc;

  // State and replay flag. The replay flag marks the lookup that follows a
  // refill so that it is not counted as a first-try hit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_replay <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_replay <= w_next_replay;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_next_replay = r_replay;
    o_mem_resp    = 1'b0;
    o_lru_write   = 1'b0;
    o_set_vals    = 1'b0;
    o_l2_read     = 1'b0;
    o_busy        = 1'b0;
    w_hit_inc     = 1'b0;
    w_miss_inc    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!i_mem_read) begin
          // Requester walked away (e.g. after an abandoned miss).
          w_next_replay = 1'b0;
        end else if (i_hit) begin
          o_mem_resp    = 1'b1;
          o_lru_write   = 1'b1;
          w_hit_inc     = !r_replay;
          w_next_replay = 1'b0;
        end else begin
          w_next_state = ALLOCATE;
          w_miss_inc   = 1'b1;
        end
      end
      ALLOCATE: begin
        o_l2_read  = 1'b1;
        o_busy     = 1'b1;
        // L2 data is only valid in the response cycle, so fill then.
        o_set_vals = i_l2_resp;
        if (i_l2_resp) begin
          w_next_state  = IDLE;
          w_next_replay = 1'b1;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_perf_clr) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_hit_inc && (r_hit_count != COUNT_MAX)) begin
        r_hit_count <= r_hit_count + 1'b1;
      end
      if (w_miss_inc && (r_miss_count != COUNT_MAX)) begin
        r_miss_count <= r_miss_count + 1'b1;
      end
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
  assign o_dbg_state  = r_state;

endmodule

// File: doc/i_cache_control.md
Name: i_cache_control

Overview:
Control FSM that sequences the two-way instruction-cache datapath: hit detection, response, LRU update, and miss refill from L2. It sits between the fetch stage (mem_read/mem_resp), the cache datapath (hit, set_vals, lru_write) and the L2 read port (l2_read/l2_resp). It also keeps saturating hit/miss performance counters.

Parameters:
COUNT_WIDTH, 16, width of hit_count and miss_count.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
mem_read  input  1  fetch request; mem_address held stable by requester until mem_resp
mem_resp  output  1  request complete; mem_rdata from datapath valid this cycle
hit  input  1  datapath hit (valid & tag match in either way), combinational from current mem_address
set_vals  output  1  datapath fill strobe; writes l2_rdata/tag/valid into the LRU-selected way
lru_write  output  1  datapath LRU update strobe for the current set
l2_read  output  1  L2 line read request; address is mem_address
l2_resp  input  1  L2 line valid on l2_rdata this cycle; one-cycle pulse
perf_clr  input  1  synchronous clear of both counters
hit_count  output  COUNT_WIDTH  saturating count of first-try hits
miss_count  output  COUNT_WIDTH  saturating count of misses
busy  output  1  high while in ALLOCATE

Behaviour:
- States: IDLE, ALLOCATE. Reset -> IDLE; outputs after reset: mem_resp=0, set_vals=0, lru_write=0, l2_read=0, busy=0, hit_count=0, miss_count=0, replay flag=0.
- IDLE, mem_read=0: all strobes 0; replay flag cleared.
- IDLE, mem_read=1, hit=1: mem_resp=1 and lru_write=1 combinationally in the same cycle (0-cycle hit latency); stay IDLE. If replay=0, hit_count increments; if replay=1, no increment and replay clears.
- IDLE, mem_read=1, hit=0: next state ALLOCATE; miss_count increments; mem_resp=0.
- ALLOCATE: l2_read=1 and busy=1 (Moore). set_vals=l2_resp (Mealy; l2_rdata valid only in the l2_resp cycle). On l2_resp: next state IDLE, replay set to 1. Without l2_resp: remain in ALLOCATE indefinitely; there is no timeout.
- Miss latency: request seen at cycle 0 -> l2_read from cycle 1 -> l2_resp at cycle k -> set_vals at cycle k -> mem_resp + lru_write at cycle k+1, from the hit replay in IDLE.
- mem_read dropping during ALLOCATE: the L2 transaction is not aborted; the fill completes normally, the FSM returns to IDLE, and replay is then cleared by mem_read=0.
- l2_resp while in IDLE is ignored: no set_vals, no state change.
- set_vals and lru_write are never high in the same cycle. mem_resp is never high in ALLOCATE.
- Counters: +1 per event; they saturate at 2^COUNT_WIDTH-1 with no wrap. perf_clr takes priority over a same-cycle increment, so the result is 0.
- Reset mid-ALLOCATE: the FSM goes to IDLE on the next edge; l2_read drops that cycle; counters clear.

Test Plan:
- Cold miss: reset, mem_read=1, hit=0, l2_resp at cycle 4 -> l2_read high cycles 1-4; set_vals only at cycle 4; mem_resp+lru_write at cycle 5 (hit=1); miss_count=1, hit_count=0.
- Back-to-back hits: hit=1 with 3 sequential mem_read requests, one cycle each -> mem_resp and lru_write in each request cycle; hit_count=3; l2_read never asserted.
- Abandoned miss: miss, then drop mem_read at cycle 2, l2_resp at cycle 6 -> set_vals at cycle 6; FSM in IDLE at cycle 7; no mem_resp; replay cleared, so the next hit counts (hit_count=1).
- Stray l2_resp in IDLE with mem_read=0 -> set_vals=0, state stays IDLE, counters unchanged.
- Saturation and clear: COUNT_WIDTH=2, 5 hits -> hit_count=3; perf_clr concurrent with a hit -> hit_count=0 on the next cycle.
- Reset in ALLOCATE at cycle 3 -> cycle 4: l2_read=0, busy=0, counters 0; l2_resp at cycle 5 -> no set_vals.
